ex_mem_pipe: RTL
================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX stage presents a valid instruction.
- in_ready  out  1  block can accept the EX instruction this cycle.
- in_result  in  64  ALU Result.
- in_zero  in  1  ALU Zero flag.
- in_rs2_data  in  64  store data.
- in_branch_target  in  64  computed branch target.
- in_rd  in  5  destination register.
- in_ctrl  in  5  control bits {branch, mem_read, mem_write, mem_to_reg, reg_write}, MSB first.
- flush  in  1  kill all held instructions.
- out_valid  out  1  MEM stage instruction valid.
- out_ready  in  1  MEM stage accepts this cycle.
- out_result, out_rs2_data, out_branch_target  out  64 each  registered copies of the matching inputs.
- out_zero  out  1  registered copy of in_zero.
- out_rd  out  5  registered copy of in_rd.
- out_ctrl  out  5  registered copy of in_ctrl.
- branch_taken  out  1  out_valid AND out_ctrl[4] AND out_zero (combinational).
- stall_count  out  32  present only with EX_MEM_STALL_CNT_EN.

Function
REQ-003 The block SHALL be a 2-entry skid buffer: a main entry M that drives the out_* ports, and a skid entry S. Each entry holds all fields plus a valid bit.
REQ-004 in_ready SHALL be a registered signal equal to NOT S.valid. No combinational path SHALL exist from out_ready to in_ready.
REQ-005 Accept SHALL be in_valid AND in_ready. Drain SHALL be out_valid AND out_ready. out_valid SHALL equal M.valid.
REQ-006 State transitions, evaluated per cycle with flush low:
- {M empty, S empty} + accept: load M; state becomes {M full, S empty}.
- {M full, S empty} + accept + drain: load M with the new data; state unchanged.
- {M full, S empty} + accept, no drain: load S; state becomes {M full, S full}; in_ready goes to 0.
- {M full, S empty} + drain, no accept: state becomes {M empty, S empty}.
- {M full, S full} + drain: move S to M; state becomes {M full, S empty}; in_ready goes to 1.
- Any other combination: hold state.
REQ-007 Ordering SHALL be strict FIFO. An accepted instruction SHALL reach out_* one cycle after acceptance when M was empty or draining.
REQ-008 Data SHALL NOT be lost or duplicated, and out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 When flush=1, both valid bits SHALL clear on the next edge and in_ready SHALL become 1. An instruction offered in the flush cycle SHALL be discarded. Flush SHALL take priority over accept and drain.
REQ-010 Data fields of an empty entry SHALL be don't-care, except out_ctrl, which SHALL read 0 whenever out_valid=0. This prevents spurious mem_write or reg_write.
REQ-011 branch_taken SHALL be 0 whenever out_valid=0.

Reset
REQ-012 While reset=1 at an edge, M.valid, S.valid and all data registers SHALL clear to 0, in_ready SHALL become 1, and stall_count (if present) SHALL become 0.
REQ-013 Reset SHALL take priority over flush, accept and drain, and SHALL discard any in-flight data when asserted mid-operation.
REQ-014 The first accept SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-015 Macro EX_MEM_STALL_CNT_EN:
- Defined: port stall_count SHALL exist. It SHALL increment by 1 on every cycle with out_valid=1 and out_ready=0, SHALL wrap from 0xFFFFFFFF to 0, and SHALL be unaffected by flush.
- Undefined: the port and counter SHALL be absent.
All other behaviour SHALL be identical in both cases.

Verification
REQ-016 Reset, then in_valid=1, in_result=64'h10, in_ctrl=5'b00011, out_ready=1 for one cycle -> next cycle out_valid=1, out_result=64'h10, out_ctrl=5'b00011; in_ready stays 1.
REQ-017 out_ready=0, two accepts A=1 and B=2 on consecutive cycles -> in_ready=0 after B and out_result=1 held. Then out_ready=1 -> out_result 1, then 2, then out_valid=0; no third accept while in_ready=0.
REQ-018 Continuous in_valid=1 with out_ready=1 and values 1..8 -> out_result shows 1..8 on consecutive cycles, no bubbles.
REQ-019 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the offered data never appears.
REQ-020 out_valid=1, in_zero=1, in_ctrl[4]=1 -> branch_taken=1. Same with in_zero=0 -> branch_taken=0.
REQ-021 With EX_MEM_STALL_CNT_EN, hold out_ready=0 for 5 cycles with out_valid=1 -> stall_count=5. Then reset=1 mid-stall -> stall_count=0, out_valid=0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (main entry M drives out_*, skid entry S).
// Optional stall counter port enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic        in_zero,
  input  logic [63:0] in_rs2_data,
  input  logic [63:0] in_branch_target,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_ctrl,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] out_rs2_data,
  output logic [63:0] out_branch_target,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_ctrl,
  output logic        branch_taken
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CTRL_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] branch_target;
    logic              zero;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, in_ent;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, drain;

  assign in_ent = '{result: in_result, rs2_data: in_rs2_data, branch_target: in_branch_target,
                    zero: in_zero, rd: in_rd, ctrl: in_ctrl};
  assign accept = in_valid & in_ready;
  assign drain  = m_valid_q & out_ready;

  // Next-state; M.ctrl is zeroed whenever M empties so out_ctrl never shows stale write enables
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_d.ctrl  = '0;
    end else if (s_valid_q) begin
      if (drain) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (accept && drain) begin
        m_d = in_ent;
      end else if (accept) begin
        s_d       = in_ent;
        s_valid_d = 1'b1;
      end else if (drain) begin
        m_valid_d = 1'b0;
        m_d.ctrl  = '0;
      end
    end else if (accept) begin
      m_d       = in_ent;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      in_ready  <= ~s_valid_d;
    end
  end

  assign out_valid         = m_valid_q;
  assign out_result        = m_q.result;
  assign out_rs2_data      = m_q.rs2_data;
  assign out_branch_target = m_q.branch_target;
  assign out_zero          = m_q.zero;
  assign out_rd            = m_q.rd;
  assign out_ctrl          = m_q.ctrl;
  assign branch_taken      = m_valid_q & m_q.ctrl[CTRL_W-1] & m_q.zero;

`ifdef EX_MEM_STALL_CNT_EN
  // Counts cycles where MEM back-pressures a valid instruction; flush does not touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (m_valid_q && !out_ready) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
